// File: rtl/keypad_row_scanner.sv
// 4x4 matrix keypad scanner: drives one row low per slot, samples the columns,
// debounces whole 16-key frames and derives paddle levels, start and new-key events.
module keypad_row_scanner #(
  parameter int CLK_DIV  = 8,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  kp_col,
  output logic [3:0]  kp_row,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        up1,
  output logic        down1,
  output logic        up2,
  output logic        down2,
  output logic        start
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);

  logic [3:0]       col_meta_q;
  logic [3:0]       col_sync_q;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [1:0]       row_q, row_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q, prev_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [15:0]      key_state_q, key_state_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             start_q, start_d;

  logic             slot_end;
  logic             frame_done;
  logic [3:0]       col_pressed;
  logic [15:0]      frame;
  logic [15:0]      new_press;

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Columns are asynchronous to clk; two flops before anything looks at them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 4'b1111;
      col_sync_q <= 4'b1111;
    end else begin
      col_meta_q <= kp_col;
      col_sync_q <= col_meta_q;
    end
  end

  always_comb begin
    slot_end    = (presc_q == PRE_LAST);
    frame_done  = slot_end && (row_q == 2'd3);
    col_pressed = ~col_sync_q;
    // The completed frame includes the row-3 sample being written this cycle.
    frame         = raw_q;
    frame[15:12]  = col_pressed;
    new_press     = frame & ~key_state_q;

    presc_d     = slot_end ? '0 : presc_q + 1'b1;
    row_d       = slot_end ? row_q + 2'd1 : row_q;
    raw_d       = raw_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    key_state_d = key_state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    start_d     = 1'b0;

    if (slot_end) begin
      raw_d[{row_q, 2'b00} +: 4] = col_pressed;
    end

    if (frame_done) begin
      prev_d = frame;
      if (frame == prev_q) begin
        stable_d = (stable_q == CNT_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
      // Re-committing an unchanged frame is harmless: new_press is then zero.
      if (stable_d == CNT_MAX) begin
        key_state_d = frame;
        if (|new_press) begin
          key_valid_d = 1'b1;
          key_code_d  = lowest_index(new_press);
        end
        start_d = new_press[15];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q     <= '0;
      row_q       <= 2'd0;
      raw_q       <= 16'd0;
      prev_q      <= 16'd0;
      stable_q    <= '0;
      key_state_q <= 16'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      start_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      row_q       <= row_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      key_state_q <= key_state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      start_q     <= start_d;
    end
  end

  assign kp_row    = ~(4'b0001 << row_q);
  assign key_state = key_state_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign start     = start_q;

  // Opposing keys of a pair cancel each other out.
  assign up1   = key_state_q[0] & ~key_state_q[4];
  assign down1 = key_state_q[4] & ~key_state_q[0];
  assign up2   = key_state_q[3] & ~key_state_q[7];
  assign down2 = key_state_q[7] & ~key_state_q[3];

endmodule

// File: tb/tb_keypad_row_scanner.sv
// Bench for keypad_row_scanner: a keypad model drives kp_col from a pressed-key map,
// expected events go to a scoreboard queue that a negedge monitor pops and compares.
module tb_keypad_row_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  kp_col;
  logic [3:0]  kp_row;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        up1, down1, up2, down2, start;

  logic [15:0] keys;

  typedef struct packed {
    logic [3:0] code;
    logic       st;
  } ev_t;

  typedef struct {
    int          id;
    logic [15:0] exp;
  } lv_t;

  ev_t exp_q[$];
  lv_t lvl_q[$];

  int checks = 0;
  int passed = 0;

  ev_t         mon_e;
  lv_t         mon_r;
  logic [15:0] mon_act;

  keypad_row_scanner #(.CLK_DIV(8), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .kp_col    (kp_col),
    .kp_row    (kp_row),
    .key_state (key_state),
    .key_valid (key_valid),
    .key_code  (key_code),
    .up1       (up1),
    .down1     (down1),
    .up2       (up2),
    .down2     (down2),
    .start     (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kp_col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp_row[r] && keys[r*4+c]) kp_col[c] = 1'b0;
      end
    end
  end

  function automatic string nm(input int id);
    case (id)
      0: return "kp_row";
      1: return "key_state";
      2: return "paddles{up1,down1,up2,down2}";
      3: return "key_valid";
      4: return "start";
      5: return "key_code";
      default: return "pending_events";
    endcase
  endfunction

  function automatic logic [15:0] act_of(input int id);
    case (id)
      0: return {12'd0, kp_row};
      1: return key_state;
      2: return {12'd0, up1, down1, up2, down2};
      3: return {15'd0, key_valid};
      4: return {15'd0, start};
      5: return {12'd0, key_code};
      default: return 16'(exp_q.size());
    endcase
  endfunction

  // Monitor: scoreboard pops on key_valid, then serves queued level checks.
  always @(negedge clk) begin
    if (key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got key_code=%0d start=%0b, required no key_valid", key_code, start);
      end else begin
        mon_e = exp_q.pop_front();
        if (key_code == mon_e.code && start == mon_e.st) passed++;
        else $display("FAIL event: got key_code=%0d start=%0b, required key_code=%0d start=%0b",
                      key_code, start, mon_e.code, mon_e.st);
      end
    end else if (start) begin
      checks++;
      $display("FAIL start_without_valid: got start=1 key_valid=0, required start only with key_valid");
    end
    while (lvl_q.size() > 0) begin
      mon_r   = lvl_q.pop_front();
      mon_act = act_of(mon_r.id);
      checks++;
      if (mon_act == mon_r.exp) passed++;
      else begin
        $display("FAIL %s: got 0x%0h, required 0x%0h", nm(mon_r.id), mon_act, mon_r.exp);
        if (mon_r.id == 6) exp_q.delete();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input int id, input logic [15:0] e);
    lvl_q.push_back('{id, e});
  endtask

  task automatic expect_ev(input logic [3:0] code, input logic st);
    exp_q.push_back('{code, st});
  endtask

  task automatic drain(input int max_cycles);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < max_cycles) begin
      tick(1);
      i++;
    end
    chk(6, 16'd0);
  endtask

  task automatic chk_quiet();
    chk(0, 16'h000E);
    chk(1, 16'h0000);
    chk(2, 16'h0000);
    chk(3, 16'h0000);
    chk(4, 16'h0000);
    chk(5, 16'h0000);
  endtask

  initial begin
    rst  = 1'b0;
    keys = 16'h0000;
    tick(3);
    chk_quiet();
    tick(1);

    // Row scan after reset: 8 cycles per row, 1110 -> 1101 -> 1011 -> 0111.
    rst = 1'b1;
    chk(0, 16'h000E);
    for (int k = 1; k < 40; k++) begin
      tick(1);
      chk(0, {12'd0, 4'b1111 ^ (4'b0001 << ((k / 8) % 4))});
    end
    chk(1, 16'h0000);
    chk(2, 16'h0000);

    // Key 0 held: one event, up1, no repeats, silent release.
    keys = 16'h0001;
    expect_ev(4'd0, 1'b0);
    drain(135);
    chk(1, 16'h0001);
    chk(2, 16'h0008);
    tick(100);
    keys = 16'h0000;
    tick(131);
    chk(1, 16'h0000);
    chk(2, 16'h0000);

    // Keys 0 and 4 together cancel the left paddle; lowest index reported.
    keys = 16'h0011;
    expect_ev(4'd0, 1'b0);
    drain(135);
    chk(1, 16'h0011);
    chk(2, 16'h0000);
    keys = 16'h0000;
    tick(131);
    chk(1, 16'h0000);

    // Key 7 bouncing: never three identical frames, so nothing commits.
    for (int t = 0; t < 10; t++) begin
      keys = keys ^ 16'h0080;
      tick(24);
    end
    chk(1, 16'h0000);
    keys = 16'h0080;
    expect_ev(4'd7, 1'b0);
    drain(135);
    chk(1, 16'h0080);
    chk(2, 16'h0001);
    chk(5, 16'h0007);
    keys = 16'h0000;
    tick(131);
    chk(2, 16'h0000);

    // Key 15: start coincides with key_valid.
    keys = 16'h8000;
    expect_ev(4'd15, 1'b1);
    drain(135);
    chk(1, 16'h8000);
    chk(2, 16'h0000);
    keys = 16'h0000;
    tick(131);
    chk(1, 16'h0000);
    chk(5, 16'h000F);

    // Key 3 held through a mid-frame reset.
    keys = 16'h0008;
    expect_ev(4'd3, 1'b0);
    drain(135);
    chk(2, 16'h0002);
    tick(13);
    rst = 1'b0;
    chk_quiet();
    tick(5);
    chk_quiet();
    rst = 1'b1;
    expect_ev(4'd3, 1'b0);
    tick(90);
    chk(1, 16'h0000);
    drain(12);
    chk(1, 16'h0008);
    chk(2, 16'h0002);
    chk(5, 16'h0003);

    tick(3);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
